trigger_sequencer: RTL

//   Upstream of the monostable one-shot: emits single-cycle trigger pulses that fire it.

---
 rtl/trigger_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/trigger_sequencer.sv
// rtl/trigger_sequencer.sv - burst/continuous trigger pulse sequencer for a downstream one-shot
//
// Purpose:
//   Emits single-cycle trigger pulses spaced by a latched period p = max(period, 2).
//   It runs either a burst of burst_len triggers followed by a trailing p-cycle wait,
//   or continuous triggers (burst_len = 0) until stop.
//   When TRIGGER_SEQUENCER_EXT_TRIG_EN is defined, the optional external-trigger
//   gating is built in: each trigger then waits for a synchronized rising edge on
//   ext_trig_in once the p-cycle holdoff has expired.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   start        in   1-cycle request to begin a burst (ignored while busy)
//   stop         in   1-cycle abort request (wins over start, suppresses trigger)
//   period       in   [PERIOD_WIDTH] cycles between triggers, latched on start
//   burst_len    in   [BURST_WIDTH] triggers per burst, 0 = continuous, latched on start
//   ext_trig_in  in   async external trigger (TRIGGER_SEQUENCER_EXT_TRIG_EN only)
//   ext_mode     in   1 = gate triggers on external edge, latched on start (same build only)
//   trigger      out  1-cycle pulse to the one-shot
//   busy         out  high from the cycle after an accepted start until back in IDLE
//   done         out  1-cycle pulse on normal burst completion
//   trig_count   out  [BURST_WIDTH] triggers issued in the current burst

module trigger_sequencer #(
   parameter int PERIOD_WIDTH = 24,
   parameter int BURST_WIDTH  = 8,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    stop,
   input  logic [PERIOD_WIDTH-1:0] period,
   input  logic [BURST_WIDTH-1:0]  burst_len,
`ifdef TRIGGER_SEQUENCER_EXT_TRIG_EN
   input  logic                    ext_trig_in,
   input  logic                    ext_mode,
`endif
   output logic                    trigger,
   output logic                    busy,
   output logic                    done,
   output logic [BURST_WIDTH-1:0]  trig_count
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_RUN      = 2'd1;
`ifdef TRIGGER_SEQUENCER_EXT_TRIG_EN
   localparam logic [1:0] ST_WAIT_EXT = 2'd2;
`endif

   generate
      if (SYNC_STAGES < 2) begin : g_sync_stages_check
         $error("SYNC_STAGES must be at least 2");
      end
   endgenerate

   logic [1:0]              state_q, state_d;
   logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
   logic [PERIOD_WIDTH-1:0] per_q, per_d;
   logic [BURST_WIDTH-1:0]  len_q, len_d;
   logic [BURST_WIDTH-1:0]  cnt_q, cnt_d;
   logic                    trig_q, trig_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [PERIOD_WIDTH-1:0] per_eff;

`ifdef TRIGGER_SEQUENCER_EXT_TRIG_EN
   logic [SYNC_STAGES-1:0]  sync_q, sync_d;
   logic                    edge_prev_q, edge_prev_d;
   logic                    ext_mode_q, ext_mode_d;
   logic                    ext_edge;

   // Pin is asynchronous: shift through the synchronizer, then detect a 0->1
   // on the last stage. The edge is used combinationally so the trigger
   // lands one cycle after detection.
   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], ext_trig_in};
      edge_prev_d = sync_q[SYNC_STAGES-1];
      ext_edge    = sync_q[SYNC_STAGES-1] & ~edge_prev_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q      <= '0;
         edge_prev_q <= 1'b0;
         ext_mode_q  <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         edge_prev_q <= edge_prev_d;
         ext_mode_q  <= ext_mode_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      per_d   = per_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      trig_d  = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef TRIGGER_SEQUENCER_EXT_TRIG_EN
      ext_mode_d = ext_mode_q;
`endif
      // Periods below 2 would make trigger back-to-back; clamp to 2.
      per_eff = (period < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(2) : period;

      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               busy_d  = 1'b1;
               timer_d = '0;
               per_d   = per_eff;
               len_d   = burst_len;
               cnt_d   = '0;
`ifdef TRIGGER_SEQUENCER_EXT_TRIG_EN
               ext_mode_d = ext_mode;
               if (ext_mode) begin
                  state_d = ST_WAIT_EXT;
               end else begin
                  state_d = ST_RUN;
                  trig_d  = 1'b1;
                  cnt_d   = BURST_WIDTH'(1);
               end
`else
               state_d = ST_RUN;
               trig_d  = 1'b1;
               cnt_d   = BURST_WIDTH'(1);
`endif
            end
         end

         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (timer_q == per_q - PERIOD_WIDTH'(1)) begin
               timer_d = '0;
               // The trailing full period after the last trigger has just
               // elapsed, so the one-shot window is complete.
               if ((len_q != '0) && (cnt_q == len_q)) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
`ifdef TRIGGER_SEQUENCER_EXT_TRIG_EN
                  if (ext_mode_q) begin
                     state_d = ST_WAIT_EXT;
                  end else begin
                     trig_d = 1'b1;
                     cnt_d  = cnt_q + BURST_WIDTH'(1);
                  end
`else
                  trig_d = 1'b1;
                  cnt_d  = cnt_q + BURST_WIDTH'(1);
`endif
               end
            end else begin
               timer_d = timer_q + PERIOD_WIDTH'(1);
            end
         end

`ifdef TRIGGER_SEQUENCER_EXT_TRIG_EN
         ST_WAIT_EXT: begin
            // Edges seen during the RUN holdoff never reach here: only an
            // edge detected while waiting releases the next trigger.
            if (stop) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end else if (ext_edge) begin
               state_d = ST_RUN;
               timer_d = '0;
               trig_d  = 1'b1;
               cnt_d   = cnt_q + BURST_WIDTH'(1);
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         per_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         trig_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         per_q   <= per_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         trig_q  <= trig_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // A stop arriving in the cycle a trigger is presented kills that pulse.
   assign trigger    = trig_q & ~stop;
   assign busy       = busy_q;
   assign done       = done_q;
   assign trig_count = cnt_q;

endmodule
